// File: rtl/mc_queue_pkg.sv
// mc_queue_pkg: shared defaults, clog2 helper and pointer/count types for mc_queue
package mc_queue_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  localparam int DATA_WIDTH_D = 16;
  localparam int DEPTH_D      = 64;
  localparam int NUM_CH_D     = 4;
  localparam int AFULL_LVL_D  = DEPTH_D - 4;
  typedef logic [clog2(DEPTH_D)-1:0] ptr_t;
  typedef logic [clog2(DEPTH_D):0]   cnt_t;
endpackage

// File: rtl/mc_queue_ctrl.sv
// mc_queue_ctrl: head/tail/count bookkeeping and flags for one logical channel
module mc_queue_ctrl
  import mc_queue_pkg::*;
#(
  parameter int DEPTH      = DEPTH_D,
  parameter int AFULL_LVL  = AFULL_LVL_D,
  parameter int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] head,
  output logic [ADDR_WIDTH-1:0] tail,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  afull,
  output logic                  empty
);
  // push/pop arrive pre-qualified by full/empty, so count cannot leave 0..DEPTH
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ADDR_WIDTH'(pop);
      tail  <= tail + ADDR_WIDTH'(push);
      count <= count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
    end
  assign full  = count == (ADDR_WIDTH+1)'(DEPTH);
  assign afull = count >= (ADDR_WIDTH+1)'(AFULL_LVL);
  assign empty = count == '0;
endmodule

// File: rtl/mc_queue.sv
// mc_queue: NUM_CH logical FIFOs over one shared storage array, first-word-fall-through reads.
// Define MC_QUEUE_ERR_EN to build the sticky overflow/underflow error flags.
module mc_queue
  import mc_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int DEPTH      = DEPTH_D,
  parameter int NUM_CH     = NUM_CH_D,
  parameter int AFULL_LVL  = DEPTH - 4,
  parameter int ADDR_WIDTH = clog2(DEPTH),
  parameter int CH_WIDTH   = clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enq_valid,
  input  logic [CH_WIDTH-1:0]   enq_ch,
  input  logic [DATA_WIDTH-1:0] enq_data,
  output logic                  enq_ready,
  input  logic                  deq_ready,
  input  logic [CH_WIDTH-1:0]   deq_ch,
  output logic                  deq_valid,
  output logic [DATA_WIDTH-1:0] deq_data,
  output logic [ADDR_WIDTH:0]   deq_level,
  output logic [NUM_CH-1:0]     full,
  output logic [NUM_CH-1:0]     afull,
  output logic [NUM_CH-1:0]     empty,
  input  logic                  err_clr,
  output logic [NUM_CH-1:0]     err_ovf,
  output logic [NUM_CH-1:0]     err_udf
);
  logic [DATA_WIDTH-1:0] mem [NUM_CH*DEPTH];
  logic [ADDR_WIDTH-1:0] head [NUM_CH];
  logic [ADDR_WIDTH-1:0] tail [NUM_CH];
  logic [ADDR_WIDTH:0]   count [NUM_CH];
  logic [NUM_CH-1:0]     enq_sel, deq_sel, push, pop;
  logic                  enq_fire, deq_fire;
  assign enq_ready = !full[enq_ch];
  assign deq_valid = !empty[deq_ch];
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_ready && deq_valid;
  assign enq_sel   = NUM_CH'(1) << enq_ch;
  assign deq_sel   = NUM_CH'(1) << deq_ch;
  assign push      = enq_sel & {NUM_CH{enq_fire}};
  assign pop       = deq_sel & {NUM_CH{deq_fire}};
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mc_queue_ctrl #(
      .DEPTH      (DEPTH),
      .AFULL_LVL  (AFULL_LVL),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .pop   (pop[g]),
      .head  (head[g]),
      .tail  (tail[g]),
      .count (count[g]),
      .full  (full[g]),
      .afull (afull[g]),
      .empty (empty[g])
    );
  end
  // Storage is deliberately unreset; stale entries are masked by deq_valid
  always_ff @(posedge clk)
    if (enq_fire) mem[{enq_ch, tail[enq_ch]}] <= enq_data;
  assign deq_data  = deq_valid ? mem[{deq_ch, head[deq_ch]}] : '0;
  assign deq_level = count[deq_ch];
`ifdef MC_QUEUE_ERR_EN
  logic [NUM_CH-1:0] ovf_set, udf_set;
  assign ovf_set = enq_sel & {NUM_CH{enq_valid && !enq_ready}};
  assign udf_set = deq_sel & {NUM_CH{deq_ready && !deq_valid}};
  // A new error in the clearing cycle survives the clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_ovf <= '0;
      err_udf <= '0;
    end else begin
      err_ovf <= (err_clr ? '0 : err_ovf) | ovf_set;
      err_udf <= (err_clr ? '0 : err_udf) | udf_set;
    end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_ovf = '0;
  assign err_udf = '0;
`endif
endmodule

// File: tb/tb_mc_queue.sv
// tb_mc_queue: directed tables, corner sequences and random traffic against per-channel queue model
module tb_mc_queue;
  localparam int DW = 16, DEPTH = 64, NCH = 4, AW = 6, CW = 2, AFL = DEPTH - 4;
  logic          clk = 0, rst_n = 0, enq_valid = 0, deq_ready = 0, err_clr = 0;
  logic [CW-1:0] enq_ch = '0, deq_ch = '0;
  logic [DW-1:0] enq_data = '0;
  logic          enq_ready, deq_valid;
  logic [DW-1:0] deq_data;
  logic [AW:0]   deq_level;
  logic [NCH-1:0] full, afull, empty, err_ovf, err_udf;
  int n_vec = 0, n_bad = 0;
  logic [DW-1:0] q [NCH][$];
  logic [NCH-1:0] m_ovf = '0, m_udf = '0;
  bit err_build;

  mc_queue dut (
    .clk(clk), .rst_n(rst_n), .enq_valid(enq_valid), .enq_ch(enq_ch), .enq_data(enq_data),
    .enq_ready(enq_ready), .deq_ready(deq_ready), .deq_ch(deq_ch), .deq_valid(deq_valid),
    .deq_data(deq_data), .deq_level(deq_level), .full(full), .afull(afull), .empty(empty),
    .err_clr(err_clr), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ev; int ec; int ed; bit dr; int dc;
    bit rdy; bit vld; int data; int lvl;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) q[c].delete();
    m_ovf = '0;
    m_udf = '0;
  endtask

  task automatic check_model();
    logic [NCH-1:0] ef, ea, ee;
    for (int c = 0; c < NCH; c++) begin
      ef[c] = q[c].size() == DEPTH;
      ea[c] = q[c].size() >= AFL;
      ee[c] = q[c].size() == 0;
    end
    chk("enq_ready", enq_ready, q[enq_ch].size() < DEPTH);
    chk("deq_valid", deq_valid, q[deq_ch].size() != 0);
    chk("deq_data", deq_data, q[deq_ch].size() != 0 ? q[deq_ch][0] : 16'h0);
    chk("deq_level", deq_level, q[deq_ch].size());
    chk("full", full, ef);
    chk("afull", afull, ea);
    chk("empty", empty, ee);
    chk("err_ovf", err_ovf, m_ovf);
    chk("err_udf", err_udf, m_udf);
  endtask

  task automatic drive(input bit ev, input int ec, input int ed, input bit dr, input int dc, input bit clr);
    enq_valid = ev;
    enq_ch    = CW'(ec);
    enq_data  = DW'(ed);
    deq_ready = dr;
    deq_ch    = CW'(dc);
    err_clr   = clr;
  endtask

  task automatic tick();
    bit ef, df;
    int ec, dc;
    ec = int'(enq_ch);
    dc = int'(deq_ch);
    ef = enq_valid && q[ec].size() < DEPTH;
    df = deq_ready && q[dc].size() > 0;
    if (err_build) begin
      if (err_clr) begin m_ovf = '0; m_udf = '0; end
      if (enq_valid && !ef) m_ovf[ec] = 1'b1;
      if (deq_ready && !df) m_udf[dc] = 1'b1;
    end
    @(posedge clk);
    if (ef) q[ec].push_back(enq_data);
    if (df) void'(q[dc].pop_front());
    #1;
  endtask

  task automatic step(input bit ev, input int ec, input int ed, input bit dr, input int dc, input bit clr);
    drive(ev, ec, ed, dr, dc, clr);
    @(negedge clk);
    check_model();
    tick();
  endtask

  initial begin
`ifdef MC_QUEUE_ERR_EN
    err_build = 1'b1;
`else
    err_build = 1'b0;
`endif
    tbl[0] = '{1, 0, 'hAAAA, 0, 0, 1, 0, 0, 0};
    tbl[1] = '{1, 1, 'hBBBB, 0, 0, 1, 1, 'hAAAA, 1};
    tbl[2] = '{0, 0, 0, 1, 1, 1, 1, 'hBBBB, 1};
    tbl[3] = '{0, 0, 0, 0, 0, 1, 1, 'hAAAA, 1};
    tbl[4] = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[5] = '{1, 0, 'h5555, 1, 0, 1, 1, 'hAAAA, 1};
    tbl[6] = '{0, 0, 0, 0, 0, 1, 1, 'h5555, 1};
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 0;
    #22 rst_n = 1;
    @(negedge clk);
    chk("rst_empty", empty, 4'hF);
    chk("rst_full", full, 4'h0);
    chk("rst_deq_data", deq_data, 0);
    step(0, 0, 0, 0, 0, 0);
    // fill ch2 to the brim
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1, 2, i, 0, 2, 0);
      @(negedge clk);
      chk("t1_afull2", afull[2], (i - 1) >= AFL);
      check_model();
      tick();
    end
    drive(0, 2, 0, 0, 2, 0);
    @(negedge clk);
    chk("t1_full", full, 4'b0100);
    chk("t1_afull", afull, 4'b0100);
    chk("t1_ready", enq_ready, 0);
    chk("t1_level", deq_level, DEPTH);
    tick();
    // drain ch2 with deq_ready held
    for (int i = 1; i <= DEPTH; i++) begin
      drive(0, 0, 0, 1, 2, 0);
      @(negedge clk);
      chk("t2_data", deq_data, i);
      check_model();
      tick();
    end
    drive(0, 0, 0, 0, 2, 0);
    @(negedge clk);
    chk("t2_valid", deq_valid, 0);
    chk("t2_data0", deq_data, 0);
    tick();
    // interleaved channels
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].ev, tbl[i].ec, tbl[i].ed, tbl[i].dr, tbl[i].dc, 0);
      @(negedge clk);
      chk("t3_ready", enq_ready, tbl[i].rdy);
      chk("t3_valid", deq_valid, tbl[i].vld);
      chk("t3_data", deq_data, tbl[i].data);
      chk("t3_level", deq_level, tbl[i].lvl);
      check_model();
      tick();
    end
    // ch3 at 63 with steady enq+deq across pointer wrap
    for (int i = 0; i < DEPTH - 1; i++) step(1, 3, 'h3000 + i, 0, 3, 0);
    for (int i = 0; i < 200; i++) begin
      drive(1, 3, 'h4000 + i, 1, 3, 0);
      @(negedge clk);
      chk("t4_level", deq_level, DEPTH - 1);
      chk("t4_data", deq_data, i < DEPTH - 1 ? 'h3000 + i : 'h4000 + i - (DEPTH - 1));
      check_model();
      tick();
    end
    // error flags
    while (q[0].size() < DEPTH) step(1, 0, 'h6000 + q[0].size(), 0, 0, 0);
    step(1, 0, 'h7777, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5_ovf", err_ovf, err_build ? 4'b0001 : 4'b0000);
    chk("t5_udf", err_udf, err_build ? 4'b0010 : 4'b0000);
    chk("t5_level", deq_level, DEPTH);
    check_model();
    tick();
    step(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("t5_ovf_clr", err_ovf, 0);
    chk("t5_udf_clr", err_udf, 0);
    tick();
    // async reset mid-burst
    rst_n = 0;
    model_clear();
    #2 rst_n = 1;
    for (int i = 0; i < 10; i++) step(1, 0, 'h5000 + i, 0, 0, 0);
    drive(1, 0, 'h500A, 0, 0, 0);
    #3 rst_n = 0;
    #1;
    model_clear();
    chk("t6_empty", empty, 4'hF);
    chk("t6_level", deq_level, 0);
    chk("t6_valid", deq_valid, 0);
    check_model();
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1;
    step(1, 0, 'h1234, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6_data", deq_data, 'h1234);
    check_model();
    tick();
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 60, $urandom_range(0, NCH - 1), $urandom_range(0, 16'hFFFF),
           $urandom_range(0, 99) < 45, $urandom_range(0, NCH - 1), $urandom_range(0, 99) < 5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
